// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch constants (XLEN, NOP encoding) and the {pc, instr, misaligned} fetch entry layout
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misaligned;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync FIFO; in clk, rst, clear_i, push_i, pop_i, data_i; out data_o (head), full_o, empty_o, count_o
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      cnt_q;
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_q + AW'(pop_i);
      wr_q  <= wr_q + AW'(push_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end
  assign data_o  = mem_q[rd_q];
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: credit-limited imem fetch with pc-tag queue and decode buffer; PC/flush/imem/decode handshakes
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] fetch_addr,
  output logic            pc_advance,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_misaligned
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 2 * XLEN + 1;
  logic [CW-1:0]   out_q, out_d, drop_q, drop_d, buf_cnt, tag_cnt;
  logic [XLEN-1:0] tag_head;
  logic [EW-1:0]   buf_in, buf_head;
  logic            credit_ok, misaligned, req_fire, mis_go, resp_ok, buf_pop;
  logic            tag_full, tag_empty, buf_full, buf_empty;
  logic            unused_flags;
  assign credit_ok      = (out_q + buf_cnt) < CW'(DEPTH);
  assign misaligned     = fetch_addr[1:0] != 2'b00;
  assign imem_req_valid = !reset && !flush && credit_ok && !misaligned;
  assign imem_req_addr  = fetch_addr;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // misaligned entries bypass memory, so they wait for older requests to drain to keep order
  assign mis_go         = !reset && !flush && credit_ok && misaligned && out_q == '0;
  assign pc_advance     = req_fire || mis_go;
  assign resp_ok        = imem_rvalid && drop_q == '0;
  assign buf_in         = mis_go ? {fetch_addr, {XLEN{1'b0}}, 1'b1} : {tag_head, imem_rdata, 1'b0};
  assign id_valid       = !reset && !buf_empty;
  assign buf_pop        = id_valid && id_ready;
  assign {id_pc, id_instr, id_misaligned} = buf_head;
  assign unused_flags   = ^{tag_full, tag_empty, buf_full, tag_cnt};
  // on flush every request still in flight becomes a response to discard
  always_comb begin
    out_d  = flush ? '0 : out_q + CW'(req_fire) - CW'(resp_ok);
    drop_d = flush ? drop_q + out_q - CW'(imem_rvalid) : drop_q - CW'(imem_rvalid && drop_q != '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag (
    .clk     (clk),
    .rst     (reset),
    .clear_i (flush),
    .push_i  (req_fire),
    .pop_i   (resp_ok),
    .data_i  (fetch_addr),
    .data_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_cnt)
  );
  fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .rst     (reset),
    .clear_i (flush),
    .push_i  (resp_ok || mis_go),
    .pop_i   (buf_pop),
    .data_i  (buf_in),
    .data_o  (buf_head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_cnt)
  );
endmodule
